// File: rtl/lsu_axi_wr_responder.sv
// lsu_axi_wr_responder: AXI4 write slave driving GPIO/LA registers with byte-strobed writes and ID-matched B responses
module lsu_axi_wr_responder #(
  parameter int          ID_W      = 3,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            lsu_axi_awvalid,
  output logic            lsu_axi_awready,
  input  logic [ID_W-1:0] lsu_axi_awid,
  input  logic [31:0]     lsu_axi_awaddr,
  input  logic [7:0]      lsu_axi_awlen,
  input  logic            lsu_axi_wvalid,
  output logic            lsu_axi_wready,
  input  logic [63:0]     lsu_axi_wdata,
  input  logic [7:0]      lsu_axi_wstrb,
  input  logic            lsu_axi_wlast,
  output logic            lsu_axi_bvalid,
  input  logic            lsu_axi_bready,
  output logic [1:0]      lsu_axi_bresp,
  output logic [ID_W-1:0] lsu_axi_bid,
  output logic [27:0]     gpio_out,
  output logic [27:0]     gpio_oe,
  output logic [31:0]     la_word,
  output logic            wr_pulse,
  output logic            proto_err
);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [1:0]      resp_q, resp_d, sel_q, sel_d;
  logic [27:0]     gpio_q, gpio_d, oe_q, oe_d;
  logic [31:0]     la_q, la_d;
  logic            pulse_q, pulse_d, perr_q, perr_d;
  logic            aw_hs, w_hs, b_hs, last_beat, wr_en;
  logic [63:0]     bmask;
  logic            unused_bits;
  assign unused_bits     = ^{lsu_axi_awaddr[11:5], lsu_axi_awaddr[2:0], lsu_axi_wdata[31:28]};
  assign lsu_axi_awready = state_q == IDLE;
  assign lsu_axi_wready  = state_q == DATA;
  assign lsu_axi_bvalid  = state_q == RESP;
  assign lsu_axi_bresp   = resp_q;
  assign lsu_axi_bid     = id_q;
  assign gpio_out        = gpio_q;
  assign gpio_oe         = oe_q;
  assign la_word         = la_q;
  assign wr_pulse        = pulse_q;
  assign proto_err       = perr_q;
  assign aw_hs     = lsu_axi_awvalid && lsu_axi_awready;
  assign w_hs      = lsu_axi_wvalid && lsu_axi_wready;
  assign b_hs      = lsu_axi_bvalid && lsu_axi_bready;
  assign last_beat = cnt_q == 8'd0;
  // Only single-beat in-window writes touch registers; error classes just drain the burst.
  assign wr_en     = w_hs && resp_q == OKAY;
  always_comb begin
    for (int i = 0; i < 8; i++) bmask[8*i +: 8] = {8{lsu_axi_wstrb[i]}};
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    resp_d  = resp_q;
    sel_d   = sel_q;
    perr_d  = perr_q;
    if (aw_hs) begin
      id_d    = lsu_axi_awid;
      cnt_d   = lsu_axi_awlen;
      sel_d   = lsu_axi_awaddr[4:3];
      resp_d  = lsu_axi_awaddr[31:12] != BASE_ADDR[31:12] ? DECERR :
                lsu_axi_awlen != 8'd0 ? SLVERR : OKAY;
      state_d = DATA;
    end
    if (w_hs) begin
      cnt_d = cnt_q - 8'd1;
      if (lsu_axi_wlast != last_beat) perr_d = 1'b1;
      if (last_beat) state_d = RESP;
    end
    if (b_hs) state_d = IDLE;
    gpio_d  = wr_en && sel_q == 2'd0 ? (gpio_q & ~bmask[27:0]) | (lsu_axi_wdata[27:0] & bmask[27:0]) : gpio_q;
    la_d    = wr_en && sel_q == 2'd0 ? (la_q & ~bmask[63:32]) | (lsu_axi_wdata[63:32] & bmask[63:32]) : la_q;
    oe_d    = wr_en && sel_q == 2'd1 ? (oe_q & ~bmask[27:0]) | (lsu_axi_wdata[27:0] & bmask[27:0]) : oe_q;
    pulse_d = wr_en && (sel_q == 2'd0 ? |lsu_axi_wstrb : sel_q == 2'd1 ? |lsu_axi_wstrb[3:0] : 1'b0);
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      resp_q  <= OKAY;
      sel_q   <= '0;
      gpio_q  <= '0;
      oe_q    <= '0;
      la_q    <= '0;
      pulse_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      resp_q  <= resp_d;
      sel_q   <= sel_d;
      gpio_q  <= gpio_d;
      oe_q    <= oe_d;
      la_q    <= la_d;
      pulse_q <= pulse_d;
      perr_q  <= perr_d;
    end
  end
endmodule

// File: tb/tb_lsu_axi_wr_responder.sv
// tb_lsu_axi_wr_responder: directed and randomized AXI write bursts checked against a register-map reference model
module tb_lsu_axi_wr_responder;
  localparam int          ID_W = 3;
  localparam logic [31:0] BASE = 32'h8000_0000;
  logic            clk = 1'b0, rst_l = 1'b0;
  logic            awvalid = 1'b0, awready;
  logic [ID_W-1:0] awid = '0;
  logic [31:0]     awaddr = '0;
  logic [7:0]      awlen = '0;
  logic            wvalid = 1'b0, wready;
  logic [63:0]     wdata = '0;
  logic [7:0]      wstrb = '0;
  logic            wlast = 1'b0;
  logic            bvalid, bready = 1'b0;
  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;
  logic [27:0]     gpio_out, gpio_oe;
  logic [31:0]     la_word;
  logic            wr_pulse, proto_err;
  int tests = 0, fails = 0;
  logic [27:0] m_gpio = '0, m_oe = '0;
  logic [31:0] m_la = '0;
  logic        m_perr = 1'b0;

  lsu_axi_wr_responder #(.ID_W(ID_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_l(rst_l),
    .lsu_axi_awvalid(awvalid), .lsu_axi_awready(awready), .lsu_axi_awid(awid),
    .lsu_axi_awaddr(awaddr), .lsu_axi_awlen(awlen),
    .lsu_axi_wvalid(wvalid), .lsu_axi_wready(wready), .lsu_axi_wdata(wdata),
    .lsu_axi_wstrb(wstrb), .lsu_axi_wlast(wlast),
    .lsu_axi_bvalid(bvalid), .lsu_axi_bready(bready), .lsu_axi_bresp(bresp), .lsu_axi_bid(bid),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .la_word(la_word),
    .wr_pulse(wr_pulse), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".gpio_out"}, 64'(gpio_out), 64'(m_gpio));
    check({tag, ".gpio_oe"}, 64'(gpio_oe), 64'(m_oe));
    check({tag, ".la_word"}, 64'(la_word), 64'(m_la));
    check({tag, ".proto_err"}, 64'(proto_err), 64'(m_perr));
  endtask

  // Register map expressed byte by byte: which register byte does each AXI lane land in.
  task automatic model_beat(input logic [1:0] sel, input logic [63:0] d, input logic [7:0] s, output logic wrote);
    logic [31:0] g, o;
    g = {4'h0, m_gpio};
    o = {4'h0, m_oe};
    wrote = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (s[i] && sel == 2'd0) begin
        if (i < 4) g[8*i +: 8] = d[8*i +: 8];
        else m_la[8*(i-4) +: 8] = d[8*i +: 8];
        wrote = 1'b1;
      end else if (s[i] && sel == 2'd1 && i < 4) begin
        o[8*i +: 8] = d[8*i +: 8];
        wrote = 1'b1;
      end
    end
    m_gpio = g[27:0];
    m_oe   = o[27:0];
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".bvalid"}, 64'(bvalid), 64'd0);
    check({tag, ".wready"}, 64'(wready), 64'd0);
    check({tag, ".bresp"}, 64'(bresp), 64'd0);
    check({tag, ".bid"}, 64'(bid), 64'd0);
    check({tag, ".wr_pulse"}, 64'(wr_pulse), 64'd0);
    check_regs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; wlast = 1'b0;
    m_gpio = '0; m_oe = '0; m_la = '0; m_perr = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    check("reset.awready", 64'(awready), 64'd1);
  endtask

  // One complete write: AW, len+1 beats (bad >= 0 flips wlast on that beat), stall cycles with bready low, B.
  task automatic xact(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [63:0] d0, input logic [7:0] s0, input int bad, input int stall);
    logic [1:0]  exp_resp;
    logic        pulse, lst;
    logic [63:0] d;
    logic [7:0]  s;
    exp_resp = addr[31:12] != BASE[31:12] ? 2'b11 : len != 8'd0 ? 2'b10 : 2'b00;
    @(negedge clk);
    check("aw.awready", 64'(awready), 64'd1);
    check("aw.bvalid", 64'(bvalid), 64'd0);
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len;
    @(negedge clk);
    awvalid = 1'b0;
    check("aw.wready_next", 64'(wready), 64'd1);
    check("aw.awready_low", 64'(awready), 64'd0);
    for (int b = 0; b <= int'(len); b++) begin
      d = b == 0 ? d0 : {$urandom, $urandom};
      s = b == 0 ? s0 : 8'($urandom);
      lst = (b == int'(len)) ^ (b == bad);
      wvalid = 1'b1; wdata = d; wstrb = s; wlast = lst;
      if (lst != (b == int'(len))) m_perr = 1'b1;
      pulse = 1'b0;
      if (exp_resp == 2'b00) model_beat(addr[4:3], d, s, pulse);
      @(negedge clk);
      check("w.wr_pulse", 64'(wr_pulse), 64'(pulse));
      if (b < int'(len)) begin
        check("w.wready", 64'(wready), 64'd1);
        check("w.bvalid_early", 64'(bvalid), 64'd0);
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("b.bvalid", 64'(bvalid), 64'd1);
    check("b.bid", 64'(bid), 64'(id));
    check("b.bresp", 64'(bresp), 64'(exp_resp));
    check("b.wready_low", 64'(wready), 64'd0);
    check_regs("b");
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall.bvalid", 64'(bvalid), 64'd1);
      check("stall.bid", 64'(bid), 64'(id));
      check("stall.bresp", 64'(bresp), 64'(exp_resp));
      check("stall.awready", 64'(awready), 64'd0);
      check("stall.wr_pulse", 64'(wr_pulse), 64'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("done.bvalid", 64'(bvalid), 64'd0);
    check("done.awready", 64'(awready), 64'd1);
    check("done.wr_pulse", 64'(wr_pulse), 64'd0);
  endtask

  initial begin
    logic [31:0] addr;
    logic [7:0]  len;
    int          bad;
    do_reset();
    xact(3'd5, BASE, 8'd0, 64'h1234_5678_0ABC_DEF0, 8'hFF, -1, 0);
    check("t1.gpio_const", 64'(gpio_out), 64'h0ABC_DEF0);
    check("t1.la_const", 64'(la_word), 64'h1234_5678);
    xact(3'd1, BASE, 8'd0, 64'h0000_0000_0FFF_FFFF, 8'h0F, -1, 0);
    xact(3'd2, BASE, 8'd0, 64'h0, 8'h01, -1, 0);
    check("strb.gpio_const", 64'(gpio_out), 64'h0FFF_FF00);
    check("strb.la_const", 64'(la_word), 64'h1234_5678);
    xact(3'd3, BASE + 32'h8, 8'd0, 64'h0000_0000_0FFF_FFFF, 8'h0F, -1, 0);
    check("oe.const", 64'(gpio_oe), 64'h0FFF_FFFF);
    xact(3'd4, 32'h1000_0000, 8'd0, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, -1, 0);
    xact(3'd6, BASE + 32'h10, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, -1, 0);
    xact(3'd7, BASE, 8'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1, 0);
    check("perr.const", 64'(proto_err), 64'd1);
    check("perr.gpio_const", 64'(gpio_out), 64'h0FFF_FF00);
    xact(3'd2, BASE + 32'h8, 8'd0, 64'h0000_0000_0000_0055, 8'h01, -1, 10);
    // W presented with no AW outstanding must be held off.
    @(negedge clk);
    wvalid = 1'b1; wdata = '1; wstrb = 8'hFF; wlast = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("early_w.wready", 64'(wready), 64'd0);
      check("early_w.wr_pulse", 64'(wr_pulse), 64'd0);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check_regs("early_w");
    // Reset while a burst is waiting for data.
    @(negedge clk);
    awvalid = 1'b1; awid = 3'd6; awaddr = BASE; awlen = 8'd0;
    @(negedge clk);
    awvalid = 1'b0;
    check("midrst.wready", 64'(wready), 64'd1);
    rst_l = 1'b0;
    m_gpio = '0; m_oe = '0; m_la = '0; m_perr = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk);
    rst_l = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst.bvalid", 64'(bvalid), 64'd0);
      check("midrst.awready", 64'(awready), 64'd1);
    end
    xact(3'd1, BASE, 8'd0, 64'hA5A5_A5A5_0123_4567, 8'hF3, -1, 0);
    xact(3'd3, BASE, 8'd255, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, -1, 2);
    for (int n = 0; n < 40; n++) begin
      addr = $urandom_range(0, 9) == 0 ? {4'h1, 28'($urandom)} : BASE | 32'($urandom_range(0, 4095));
      len  = $urandom_range(0, 4) == 0 ? 8'($urandom_range(1, 3)) : 8'd0;
      bad  = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, int'(len))) : -1;
      xact(ID_W'($urandom), addr, len, {$urandom, $urandom}, 8'($urandom), bad, int'($urandom_range(0, 3)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
